cw_sample_buffer: RTL and testbench

- Capture-memory stage directly downstream of the ChipWatcher core.
- Consumes the core's write strobes (wt_ce, wt_en, wt_addr) and writes the probe vector (non-bus plus bus nodes) into an on-chip sample RAM.
- After capture ends, streams the stored samples oldest-first over a valid/ready port to the dump/upload logic.
- Single clock domain: the trigger clock.

---
 rtl/cw_buf_pkg.sv | 32 +++
 rtl/cw_buf_ram.sv | 26 ++
 rtl/cw_sample_buffer.sv | 176 +++++++++++++++++
 tb/tb_cw_sample_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_buf_pkg.sv
// Shared types and helpers for the ChipWatcher sample buffer.
// CW_BUF_TIMESTAMP_EN widens each stored sample by a TS_WIDTH timestamp.
package cw_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

  localparam int TS_WIDTH = 16;

`ifdef CW_BUF_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif

  // Oldest sample: one past the newest once the ring has wrapped,
  // otherwise count entries back from the newest.
  function automatic logic [31:0] dump_start_addr(input logic [31:0] last_addr,
                                                  input logic [31:0] count,
                                                  input logic        wrapped,
                                                  input int          abits);
    logic [31:0] mask;
    mask = (32'd1 << abits) - 32'd1;
    if (wrapped) return (last_addr + 32'd1) & mask;
    else         return (last_addr + 32'd1 - count) & mask;
  endfunction

endpackage

// File: rtl/cw_buf_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module cw_buf_ram #(
  parameter  int WIDTH = 89,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cw_sample_buffer.sv
// Capture RAM behind the ChipWatcher core: records probe samples while armed,
// then streams them oldest-first. CW_BUF_TIMESTAMP_EN prepends a 16-bit timestamp.
module cw_sample_buffer
  import cw_buf_pkg::*;
#(
  parameter  int DATA_WIDTH    = 89,
  parameter  int ADDR_BITS     = 10,
  parameter  int WT_ADDR_WIDTH = 16,
  localparam int OUT_W         = DATA_WIDTH + TS_EN * TS_WIDTH
) (
  input  logic                     trig_clk,
  input  logic                     rstn,
  input  logic                     arm,
  input  logic                     wt_ce,
  input  logic                     wt_en,
  input  logic [WT_ADDR_WIDTH-1:0] wt_addr,
  input  logic [DATA_WIDTH-1:0]    probe_din,
  input  logic                     dump_start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic [1:0]               state_o,
  output logic [ADDR_BITS:0]       sample_count,
  output logic                     wrapped,
  output logic                     addr_ovf
);

  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   ONE_C     = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  state_t                state, state_nxt;
  logic                  wt_en_q, wt_fall, wr_req, wr_ok, addr_hi, dump_go, pop, rd_en;
  logic [ADDR_BITS-1:0]  wr_addr, last_addr, rd_ptr;
  logic [ADDR_BITS:0]    words_left;
  logic [OUT_W-1:0]      wr_word, rd_word, skid_data;
  logic                  rd_pend, rd_pend_last, skid_valid, skid_last;
  logic [1:0]            occ;

  assign wr_addr = wt_addr[ADDR_BITS-1:0];
  assign addr_hi = |wt_addr[WT_ADDR_WIDTH-1:ADDR_BITS];
  assign wr_req  = (state == ST_ARMED) && wt_ce && wt_en && !arm;
  assign wr_ok   = wr_req && !addr_hi;
  assign wt_fall = wt_en_q && !wt_en;
  assign dump_go = (state == ST_DONE) && dump_start && !arm;
  assign pop     = out_valid && out_ready;
  assign state_o = state;

`ifdef CW_BUF_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;
  always_ff @(posedge trig_clk or negedge rstn) begin
    if (!rstn)    ts <= '0;
    else if (arm) ts <= '0;
    else          ts <= ts + TS_WIDTH'(1);
  end
  assign wr_word = {ts, probe_din};
`else
  assign wr_word = probe_din;
`endif

  always_ff @(posedge trig_clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (arm) state_nxt = ST_ARMED;
    else begin
      case (state)
        ST_ARMED: if (wt_fall && sample_count != '0) state_nxt = ST_DONE;
        ST_DONE:  if (dump_start)                    state_nxt = ST_DUMP;
        ST_DUMP:  if (pop && out_last)               state_nxt = ST_DONE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge trig_clk or negedge rstn) begin
    if (!rstn) begin
      wt_en_q      <= 1'b0;
      last_addr    <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      addr_ovf     <= 1'b0;
    end else begin
      wt_en_q <= wt_en;
      if (arm) begin
        last_addr    <= '0;
        sample_count <= '0;
        wrapped      <= 1'b0;
        addr_ovf     <= 1'b0;
      end else if (wr_req) begin
        if (addr_hi) addr_ovf <= 1'b1;
        else begin
          last_addr <= wr_addr;
          if (sample_count != DEPTH_CNT) sample_count <= sample_count + ONE_C;
          // Wrap = a write to the top address directly followed by one to 0.
          if (sample_count != '0 && last_addr == ADDR_MAX && wr_addr == '0) wrapped <= 1'b1;
        end
      end
    end
  end

  cw_buf_ram #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_ram (
    .clk   (trig_clk),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // Words held downstream (output reg, skid reg, read in flight); a new read
  // is issued only if its data will still have a slot with no pop next cycle.
  assign occ   = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend);
  assign rd_en = (state == ST_DUMP) && !arm && (words_left != '0) && (occ <= 2'(pop) + 2'd1);

  always_ff @(posedge trig_clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr       <= '0;
      words_left   <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      skid_last    <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
    end else if (arm) begin
      words_left <= '0;
      rd_pend    <= 1'b0;
      skid_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      rd_pend_last <= (words_left == ONE_C);
      if (dump_go) begin
        rd_ptr     <= ADDR_BITS'(dump_start_addr(32'(last_addr), 32'(sample_count),
                                                 wrapped, ADDR_BITS));
        words_left <= sample_count;
      end else if (rd_en) begin
        rd_ptr     <= rd_ptr + ADDR_ONE;
        words_left <= words_left - ONE_C;
      end
      if (!out_valid || pop) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_last   <= skid_last;
          skid_valid <= rd_pend;
          skid_data  <= rd_word;
          skid_last  <= rd_pend_last;
        end else if (rd_pend) begin
          out_valid <= 1'b1;
          out_data  <= rd_word;
          out_last  <= rd_pend_last;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_valid <= 1'b1;
        skid_data  <= rd_word;
        skid_last  <= rd_pend_last;
      end
    end
  end

endmodule

// File: tb/tb_cw_sample_buffer.sv
// Self-checking bench for cw_sample_buffer: vector table for capture status,
// scoreboard queue for every streamed word, hand sequences for dump corners.
module tb_cw_sample_buffer;
  localparam int DW = 89;
  localparam int OW = DW + cw_buf_pkg::TS_EN * cw_buf_pkg::TS_WIDTH;
  localparam int NV = 14;

  logic          clk = 1'b0;
  logic          rstn, arm, wt_ce, wt_en, dump_start, out_ready;
  logic [15:0]   wt_addr;
  logic [DW-1:0] probe_din;
  logic          out_valid, out_last, wrapped, addr_ovf;
  logic [OW-1:0] out_data;
  logic [1:0]    state_o;
  logic [10:0]   sample_count;

  int n_chk = 0;
  int n_fail = 0;
  int pop_cnt = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic          arm, ce, en;
    logic [15:0]   addr;
    logic [DW-1:0] din;
    logic [1:0]    st;
    logic [10:0]   cnt;
    logic          wr, ovf;
  } vec_t;
  vec_t vt[NV];

  logic          hold_pend = 1'b0;
  logic [OW-1:0] hold_data;
  logic          hold_last;
  logic [3:0]    pat = 4'b1001;

  always #5 clk = ~clk;

  cw_sample_buffer dut (
    .trig_clk(clk), .rstn(rstn), .arm(arm), .wt_ce(wt_ce), .wt_en(wt_en),
    .wt_addr(wt_addr), .probe_din(probe_din), .dump_start(dump_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .state_o(state_o), .sample_count(sample_count),
    .wrapped(wrapped), .addr_ovf(addr_ovf)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic c, input logic e, input logic [15:0] ad,
                              input logic [DW-1:0] d, input logic [1:0] s, input logic [10:0] n,
                              input logic w, input logic o);
    vec_t v;
    v.arm = a; v.ce = c; v.en = e; v.addr = ad; v.din = d;
    v.st = s; v.cnt = n; v.wr = w; v.ovf = o;
    return v;
  endfunction

  // Output monitor: scoreboard compare on each handshake, stability while stalled.
  always @(negedge clk) begin
    if (hold_pend) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, hold_data);
      check("stall_last", out_last, hold_last);
    end
    hold_pend = out_valid && !out_ready && !arm;
    hold_data = out_data;
    hold_last = out_last;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("dump_data", out_data[DW-1:0], mon_e.data);
        check("dump_last", out_last, mon_e.last);
      end
      pop_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [DW-1:0] d);
    wt_ce = 1'b1; wt_en = 1'b1; wt_addr = a; probe_din = d; cyc();
  endtask

  task automatic close_window();
    wt_ce = 1'b0; wt_en = 1'b0; cyc();
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.data = d; e.last = l;
    sb.push_back(e);
  endtask

  task automatic run_dump(input bit bp, input int budget);
    int c = 0;
    dump_start = 1'b1; out_ready = 1'b1; cyc(); dump_start = 1'b0;
    while (state_o != 2'd2 && c < budget) begin
      if (bp) out_ready = pat[c % 4];
      cyc();
      c++;
    end
    check("dump_in_budget", (c < budget), 1'b1);
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base;
    rstn = 1'b0; arm = 1'b0; wt_ce = 1'b0; wt_en = 1'b0; wt_addr = '0;
    probe_din = '0; dump_start = 1'b0; out_ready = 1'b1;

    vt[0] = mk(1, 0, 0, 16'h0, '0, 2'd1, 11'd0, 0, 0);
    for (int i = 0; i < 10; i++)
      vt[1+i] = mk(0, 1, 1, 16'(i), DW'(32'h100 + i), 2'd1, 11'(i + 1), 0, 0);
    vt[11] = mk(0, 0, 0, 16'h0, '0, 2'd2, 11'd10, 0, 0);
    vt[12] = mk(0, 1, 1, 16'h3, DW'(32'hdead), 2'd2, 11'd10, 0, 0);
    vt[13] = mk(0, 0, 0, 16'h0, '0, 2'd2, 11'd10, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_o, 2'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_count", sample_count, 11'd0);
    check("rst_wrapped", wrapped, 1'b0);
    check("rst_ovf", addr_ovf, 1'b0);
    check("rst_data", out_data, '0);
    rstn = 1'b1;
    cyc();

    // Linear capture 0..9, then a write attempt outside ARMED.
    for (int i = 0; i < NV; i++) begin
      arm = vt[i].arm; wt_ce = vt[i].ce; wt_en = vt[i].en;
      wt_addr = vt[i].addr; probe_din = vt[i].din;
      cyc();
      check($sformatf("vec%0d_state", i), state_o, vt[i].st);
      check($sformatf("vec%0d_count", i), sample_count, vt[i].cnt);
      check($sformatf("vec%0d_wrapped", i), wrapped, vt[i].wr);
      check($sformatf("vec%0d_ovf", i), addr_ovf, vt[i].ovf);
    end
    arm = 1'b0; wt_ce = 1'b0; wt_en = 1'b0;

    // First dump: 2-cycle start latency, then one word per cycle.
    for (int i = 0; i < 10; i++) push(DW'(32'h100 + i), i == 9);
    dump_start = 1'b1; out_ready = 1'b1; cyc(); dump_start = 1'b0;
    k = 0;
    while (!(out_valid && out_last) && k < 100) begin cyc(); k++; end
    check("dump_last_cycle", k, 11);
    cyc();
    check("dump_end_state", state_o, 2'd2);
    check("dump_end_valid", out_valid, 1'b0);

    // Repeat dump under backpressure 1,0,0,1.
    base = pop_cnt;
    for (int i = 0; i < 10; i++) push(DW'(32'h100 + i), i == 9);
    run_dump(1'b1, 200);
    check("bp_words", pop_cnt - base, 10);
    check("bp_sb_empty", sb.size(), 0);

    // Wrap: 1124 writes across a 1024-deep ring.
    do_arm();
    for (int i = 0; i < 1124; i++) wr(16'(i % 1024), DW'(i));
    close_window();
    check("wrap_wrapped", wrapped, 1'b1);
    check("wrap_count", sample_count, 11'd1024);
    check("wrap_state", state_o, 2'd2);
    for (int j = 0; j < 1024; j++) push(DW'(100 + j), j == 1023);
    run_dump(1'b0, 1200);
    check("wrap_sb_empty", sb.size(), 0);

    // Address overflow: dropped writes leave count and RAM intact.
    do_arm();
    check("arm_clears_wrapped", wrapped, 1'b0);
    for (int i = 0; i < 10; i++) wr(16'(i), DW'(32'h200 + i));
    wr(16'h0400, DW'(32'hbad));
    check("ovf_flag", addr_ovf, 1'b1);
    check("ovf_count", sample_count, 11'd10);
    wr(16'h0405, DW'(32'hbeef));
    check("ovf_count2", sample_count, 11'd10);
    close_window();
    check("ovf_state", state_o, 2'd2);
    for (int i = 0; i < 10; i++) push(DW'(32'h200 + i), i == 9);
    run_dump(1'b0, 200);
    check("ovf_sb_empty", sb.size(), 0);

    // Arm while word 3 of 10 is presented.
    base = pop_cnt;
    for (int i = 0; i < 3; i++) push(DW'(32'h200 + i), 1'b0);
    dump_start = 1'b1; out_ready = 1'b1; cyc(); dump_start = 1'b0;
    k = 0;
    while (pop_cnt != base + 3 && k < 100) begin cyc(); k++; end
    check("abort_reach_word3", pop_cnt - base, 3);
    out_ready = 1'b0; arm = 1'b1;
    cyc();
    arm = 1'b0;
    check("abort_valid", out_valid, 1'b0);
    check("abort_state", state_o, 2'd1);
    check("abort_count", sample_count, 11'd0);
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("abort_flushed", out_valid, 1'b0);
    check("abort_sb_empty", sb.size(), 0);

    // Empty capture window: no writes, so no transition to DONE.
    wt_ce = 1'b0; wt_en = 1'b1; cyc(); cyc();
    wt_en = 1'b0; cyc(); cyc();
    check("empty_state", state_o, 2'd1);
    dump_start = 1'b1; cyc(); dump_start = 1'b0; cyc();
    check("empty_dump_state", state_o, 2'd1);
    check("empty_dump_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
